// File: rtl/fighter_action_seq.sv
// Per-player action sequencer: maps key inputs and incoming hits to a character
// state code, an animation frame index and one-cycle step/hit pulses.
module fighter_action_seq #(
  parameter int TICKS_PER_FRAME  = 4,
  parameter int STAND_FRAMES     = 8,
  parameter int MOVE_FRAMES      = 5,
  parameter int ATTACK_FRAMES    = 9,
  parameter int HURT_FRAMES      = 4,
  parameter int DEFEND_FRAMES    = 1,
  parameter int ATTACK_HIT_FRAME = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       key_defend,
  input  logic       hit_in,
  output logic [7:0] char_state,
  output logic [7:0] frame_num,
  output logic       move_l,
  output logic       move_r,
  output logic       attack_hit,
  output logic       busy
);

  localparam int CW = $clog2(TICKS_PER_FRAME) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_FRAME - 1);
  localparam logic [7:0]    HIT_FRAME = 8'(ATTACK_HIT_FRAME);

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_ATTACK = 3'd1,
    ST_MOVEL  = 3'd2,
    ST_MOVER  = 3'd3,
    ST_HURT   = 3'd4,
    ST_DEFEND = 3'd5
  } state_t;

  state_t        state_q, state_d, nxt;
  logic [7:0]    frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          f1_q, f2_q;
  logic          move_l_q, move_l_d, move_r_q, move_r_d;
  logic          attack_hit_q, attack_hit_d, busy_q, busy_d;
  logic          tick, step, eff_hit;

  function automatic logic [7:0] last_frame(input state_t s);
    case (s)
      ST_STAND:  last_frame = 8'(STAND_FRAMES - 1);
      ST_ATTACK: last_frame = 8'(ATTACK_FRAMES - 1);
      ST_MOVEL,
      ST_MOVER:  last_frame = 8'(MOVE_FRAMES - 1);
      ST_HURT:   last_frame = 8'(HURT_FRAMES - 1);
      ST_DEFEND: last_frame = 8'(DEFEND_FRAMES - 1);
      default:   last_frame = 8'd0;
    endcase
  endfunction

  function automatic state_t prio(input logic pend, input logic l, input logic r,
                                  input logic a, input logic d);
    if (pend)          prio = ST_HURT;
    else if (a)        prio = ST_ATTACK;
    else if (d)        prio = ST_DEFEND;
    else if (l && !r)  prio = ST_MOVEL;
    else if (r && !l)  prio = ST_MOVER;
    else               prio = ST_STAND;
  endfunction

  assign tick = f1_q & ~f2_q;
  assign step = tick & (cnt_q == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_STAND;
      frame_q      <= 8'd0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      f1_q         <= 1'b0;
      f2_q         <= 1'b0;
      move_l_q     <= 1'b0;
      move_r_q     <= 1'b0;
      attack_hit_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      f1_q         <= frame_clk;
      f2_q         <= f1_q;
      move_l_q     <= move_l_d;
      move_r_q     <= move_r_d;
      attack_hit_q <= attack_hit_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    nxt     = state_q;
    eff_hit = pend_q;
    if (hit_in && state_q != ST_HURT) pend_d = 1'b1;
    if (tick) begin
      cnt_d = step ? '0 : cnt_q + CW'(1);
      if (state_q == ST_ATTACK || state_q == ST_HURT) begin
        // One-shot: keys only matter once the final frame has been shown.
        if (step) begin
          if (frame_q == last_frame(state_q)) begin
            nxt     = prio(pend_q, key_left, key_right, key_attack, key_defend);
            state_d = nxt;
            frame_d = 8'd0;
            if (nxt == ST_HURT) pend_d = 1'b0;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end else begin
        // Defend soaks up a pending hit instead of going to hurt.
        if (state_q == ST_DEFEND && pend_q) begin
          eff_hit = 1'b0;
          pend_d  = 1'b0;
        end
        nxt = prio(eff_hit, key_left, key_right, key_attack, key_defend);
        if (nxt != state_q) begin
          state_d = nxt;
          frame_d = 8'd0;
          cnt_d   = '0;
          if (nxt == ST_HURT) pend_d = 1'b0;
        end else if (step) begin
          frame_d = (frame_q == last_frame(state_q)) ? 8'd0 : frame_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    move_l_d     = tick && (state_d == ST_MOVEL);
    move_r_d     = tick && (state_d == ST_MOVER);
    busy_d       = (state_d == ST_ATTACK) || (state_d == ST_HURT);
    attack_hit_d = tick && (state_d == ST_ATTACK) && (frame_d == HIT_FRAME) &&
                   ((state_q != ST_ATTACK) || (frame_q != frame_d));
  end

  assign char_state = {5'd0, state_q};
  assign frame_num  = frame_q;
  assign move_l     = move_l_q;
  assign move_r     = move_r_q;
  assign attack_hit = attack_hit_q;
  assign busy       = busy_q;

endmodule
